// File: rtl/wqe_dispatcher.sv
// Work-queue consumer: pops 112-bit WQEs from a FWFT FIFO and writes one 4-word
// descriptor per data segment to the RdDCS or WrDCS slave over Avalon-MM.
module wqe_dispatcher #(
    parameter logic [7:0] DCS_BASE = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wqeEmpty,
    input  logic [111:0]     wqeData,
    output logic             wqePop,
    output logic             dcsRdSelect,
    output logic             dcsWrSelect,
    output logic             dcsWrite,
    output logic [7:0]       dcsAddress,
    output logic [31:0]      dcsWriteData,
    output logic [3:0]       dcsByteEnable,
    input  logic             dcsRdWaitRequest,
    input  logic             dcsWrWaitRequest,
    output logic             busy,
    output logic             errPulse,
    output logic [CNT_W-1:0] wqeCount,
    output logic [2:0]       dbgState
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_W0   = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_W2   = 3'd4;
    localparam logic [2:0] S_W3   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [111:0]     wqe_q, wqe_d;
    logic [1:0]       seg_idx_q, seg_idx_d;
    logic [63:0]      offset_q, offset_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]  opcode;
    logic [2:0]  data_num;
    logic [7:0]  tid;
    logic [63:0] base;
    logic [7:0]  seg_len;
    logic [63:0] seg_addr;
    logic        reject;
    logic        last_seg;
    logic        in_word;
    logic        sel_wait;
    logic        accept;
    logic [1:0]  word_idx;

    assign opcode   = wqe_q[111:107];
    assign data_num = wqe_q[106:104];
    assign tid      = wqe_q[103:96];
    assign base     = wqe_q[63:0];
    assign seg_addr = base + offset_q;
    assign reject   = (opcode > 5'd1) || (data_num == 3'd0) || (data_num > 3'd4);
    assign last_seg = ({1'b0, seg_idx_q} == (data_num - 3'd1));

    always_comb begin
        seg_len = wqe_q[95:88];
        case (seg_idx_q)
            2'd0: seg_len = wqe_q[95:88];
            2'd1: seg_len = wqe_q[87:80];
            2'd2: seg_len = wqe_q[79:72];
            2'd3: seg_len = wqe_q[71:64];
            default: seg_len = wqe_q[95:88];
        endcase
    end

    always_comb begin
        in_word  = 1'b1;
        word_idx = 2'd0;
        case (state_q)
            S_W0: word_idx = 2'd0;
            S_W1: word_idx = 2'd1;
            S_W2: word_idx = 2'd2;
            S_W3: word_idx = 2'd3;
            default: in_word = 1'b0;
        endcase
    end

    // Only the waitrequest of the slave being addressed can stall the word.
    assign sel_wait = (opcode == 5'd0) ? dcsRdWaitRequest : dcsWrWaitRequest;
    assign accept   = in_word && !sel_wait;

    always_comb begin
        state_d   = state_q;
        wqe_d     = wqe_q;
        seg_idx_d = seg_idx_q;
        offset_d  = offset_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (!wqeEmpty) begin
                    wqe_d   = wqeData;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (reject) begin
                    state_d = S_IDLE;
                end else begin
                    seg_idx_d = 2'd0;
                    offset_d  = 64'd0;
                    state_d   = S_W0;
                end
            end
            S_W0: if (accept) state_d = S_W1;
            S_W1: if (accept) state_d = S_W2;
            S_W2: if (accept) state_d = S_W3;
            S_W3: begin
                if (accept) begin
                    offset_d  = offset_q + {54'd0, seg_len, 2'b00};
                    seg_idx_d = seg_idx_q + 2'd1;
                    if (last_seg) begin
                        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_W0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wqe_q     <= '0;
            seg_idx_q <= 2'd0;
            offset_q  <= 64'd0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wqe_q     <= wqe_d;
            seg_idx_q <= seg_idx_d;
            offset_q  <= offset_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        dcsWriteData = 32'd0;
        if (in_word) begin
            case (word_idx)
                2'd0: dcsWriteData = seg_addr[31:0];
                2'd1: dcsWriteData = seg_addr[63:32];
                2'd2: dcsWriteData = {22'd0, seg_len, 2'b00};
                2'd3: dcsWriteData = {1'b1, last_seg, 14'd0, tid, 6'd0, seg_idx_q};
                default: dcsWriteData = 32'd0;
            endcase
        end
    end

    // Pop is gated by reset so that outputs read 0 while reset is held, even with a non-empty FIFO.
    assign wqePop        = (state_q == S_IDLE) && !wqeEmpty && reset;
    assign dcsWrite      = in_word;
    assign dcsRdSelect   = in_word && (opcode == 5'd0);
    assign dcsWrSelect   = in_word && (opcode != 5'd0);
    assign dcsAddress    = in_word ? (DCS_BASE + {4'd0, word_idx, 2'b00}) : 8'd0;
    assign dcsByteEnable = in_word ? 4'hF : 4'h0;
    assign busy          = (state_q != S_IDLE);
    assign errPulse      = (state_q == S_LOAD) && reject;
    assign wqeCount      = count_q;
    assign dbgState      = state_q;

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Directed bench for wqe_dispatcher: FWFT FIFO model on the pop side, accepted-word
// capture on the DCS side, expected words written out by hand per scenario.
module tb_wqe_dispatcher;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         wqeEmpty;
  logic [111:0] wqeData;
  logic         wqePop;
  logic         dcsRdSelect;
  logic         dcsWrSelect;
  logic         dcsWrite;
  logic [7:0]   dcsAddress;
  logic [31:0]  dcsWriteData;
  logic [3:0]   dcsByteEnable;
  logic         dcsRdWaitRequest = 1'b0;
  logic         dcsWrWaitRequest = 1'b0;
  logic         busy;
  logic         errPulse;
  logic [15:0]  wqeCount;
  logic [2:0]   dbgState;

  always #5 clock = ~clock;

  wqe_dispatcher dut (
    .clock            (clock),
    .reset            (reset),
    .wqeEmpty         (wqeEmpty),
    .wqeData          (wqeData),
    .wqePop           (wqePop),
    .dcsRdSelect      (dcsRdSelect),
    .dcsWrSelect      (dcsWrSelect),
    .dcsWrite         (dcsWrite),
    .dcsAddress       (dcsAddress),
    .dcsWriteData     (dcsWriteData),
    .dcsByteEnable    (dcsByteEnable),
    .dcsRdWaitRequest (dcsRdWaitRequest),
    .dcsWrWaitRequest (dcsWrWaitRequest),
    .busy             (busy),
    .errPulse         (errPulse),
    .wqeCount         (wqeCount),
    .dbgState         (dbgState)
  );

  // FWFT FIFO model
  logic [111:0] fifo_mem [0:7];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign wqeEmpty = (wr_ptr == rd_ptr);
  assign wqeData  = fifo_mem[rd_ptr % 8];
  always @(posedge clock) if (wqePop) rd_ptr <= rd_ptr + 1;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // capture of accepted words: {rdSel, wrSel, address, data}
  logic [41:0] cap_q[$];
  logic [41:0] exp_q[$];
  int pop_cyc_q[$];
  int last_w3_cyc_q[$];
  int pop_cnt = 0;
  int err_cnt = 0;
  int be_bad = 0;
  int pop_bad = 0;

  always @(negedge clock) begin
    if (reset) begin
      if (dcsWrite && ((dcsRdSelect && !dcsRdWaitRequest) || (dcsWrSelect && !dcsWrWaitRequest))) begin
        cap_q.push_back({dcsRdSelect, dcsWrSelect, dcsAddress, dcsWriteData});
        if (dcsAddress == 8'h0C && dcsWriteData[30]) last_w3_cyc_q.push_back(cyc);
      end
      if (dcsWrite && dcsByteEnable != 4'hF) be_bad++;
      if (wqePop) begin
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
        if (wqeEmpty || busy) pop_bad++;
      end
      if (errPulse) err_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b01;

  function automatic logic [111:0] mk_wqe(input logic [4:0] op, input logic [2:0] dn,
                                          input logic [7:0] tid, input logic [7:0] l0,
                                          input logic [7:0] l1, input logic [7:0] l2,
                                          input logic [7:0] l3, input logic [63:0] base);
    return {op, dn, tid, l0, l1, l2, l3, base};
  endfunction

  task automatic push_wqe(input logic [111:0] w);
    fifo_mem[wr_ptr % 8] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic exp_word(input logic [1:0] sel, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({sel, a, d});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!(rd_ptr == wr_ptr && !busy) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout busy=%0b rd_ptr=%0d wr_ptr=%0d after %0d cycles", name, busy, rd_ptr, wr_ptr, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({wqePop, dcsRdSelect, dcsWrSelect, dcsWrite, busy, errPulse} !== 6'd0 ||
        dcsAddress !== 8'd0 || dcsWriteData !== 32'd0 || dcsByteEnable !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got pop=%0b rs=%0b ws=%0b wr=%0b busy=%0b err=%0b a=%h d=%h be=%h want all 0",
               wqePop, dcsRdSelect, dcsWrSelect, dcsWrite, busy, errPulse, dcsAddress, dcsWriteData, dcsByteEnable);
    end
    checks++;
    if (wqeCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", wqeCount);
    end
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || dcsWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%0b write=%0b want 0 0", busy, dcsWrite);
    end
  endtask

  task automatic test_single();
    cap_q.delete();
    exp_q.delete();
    push_wqe(mk_wqe(5'd0, 3'd1, 8'h5A, 8'h10, 8'h00, 8'h00, 8'h00, 64'h0000_1234_5678_9ABC));
    #1;
    checks++;
    if (wqePop !== 1'b1) begin
      errors++;
      $display("FAIL t1_pop got %0b want 1", wqePop);
    end
    step();
    checks++;
    if (busy !== 1'b1 || dcsWrite !== 1'b0 || wqePop !== 1'b0) begin
      errors++;
      $display("FAIL t1_load got busy=%0b write=%0b pop=%0b want 1 0 0", busy, dcsWrite, wqePop);
    end
    step();
    checks++;
    if (dcsWrite !== 1'b1 || dcsRdSelect !== 1'b1 || dcsWrSelect !== 1'b0 || dcsAddress !== 8'h00 ||
        dcsByteEnable !== 4'hF || dcsWriteData !== 32'h5678_9ABC) begin
      errors++;
      $display("FAIL t1_first_w0 got wr=%0b rs=%0b ws=%0b a=%h be=%h d=%h want 1 1 0 00 f 56789abc",
               dcsWrite, dcsRdSelect, dcsWrSelect, dcsAddress, dcsByteEnable, dcsWriteData);
    end
    exp_word(RD, 8'h00, 32'h5678_9ABC);
    exp_word(RD, 8'h04, 32'h0000_1234);
    exp_word(RD, 8'h08, 32'h0000_0040);
    exp_word(RD, 8'h0C, 32'hC000_5A00);
    wait_done(40, "t1");
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t1_words got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t1_word%0d got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wqeCount !== 16'd1) begin
      errors++;
      $display("FAIL t1_count got %0d want 1", wqeCount);
    end
  endtask

  task automatic test_multi_seg();
    cap_q.delete();
    exp_q.delete();
    dcsRdWaitRequest = 1'b1;
    push_wqe(mk_wqe(5'd1, 3'd3, 8'h33, 8'd4, 8'd0, 8'd8, 8'd0, 64'h0000_0000_0000_1000));
    exp_word(WR, 8'h00, 32'h0000_1000);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_0010);
    exp_word(WR, 8'h0C, 32'h8000_3300);
    exp_word(WR, 8'h00, 32'h0000_1010);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_0000);
    exp_word(WR, 8'h0C, 32'h8000_3301);
    exp_word(WR, 8'h00, 32'h0000_1010);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_0020);
    exp_word(WR, 8'h0C, 32'hC000_3302);
    wait_done(60, "t2");
    dcsRdWaitRequest = 1'b0;
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t2_words got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t2_word%0d got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wqeCount !== 16'd2) begin
      errors++;
      $display("FAIL t2_count got %0d want 2", wqeCount);
    end
  endtask

  task automatic test_backpressure();
    logic [46:0] snap;
    int n;
    cap_q.delete();
    exp_q.delete();
    push_wqe(mk_wqe(5'd0, 3'd1, 8'h11, 8'd1, 8'd0, 8'd0, 8'd0, 64'h2000_0000_0000_0040));
    n = 0;
    while (!(dcsWrite === 1'b1 && dcsAddress === 8'h04) && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL t3_reach_w1 got write=%0b addr=%h want 1 04", dcsWrite, dcsAddress);
    end
    dcsRdWaitRequest = 1'b1;
    snap = {dcsWrite, dcsRdSelect, dcsWrSelect, dcsAddress, dcsWriteData, dcsByteEnable};
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if ({dcsWrite, dcsRdSelect, dcsWrSelect, dcsAddress, dcsWriteData, dcsByteEnable} !== snap) begin
        errors++;
        $display("FAIL t3_hold%0d got %h want %h", k,
                 {dcsWrite, dcsRdSelect, dcsWrSelect, dcsAddress, dcsWriteData, dcsByteEnable}, snap);
      end
      if (k == 5) dcsRdWaitRequest = 1'b0;
    end
    exp_word(RD, 8'h00, 32'h0000_0040);
    exp_word(RD, 8'h04, 32'h2000_0000);
    exp_word(RD, 8'h08, 32'h0000_0004);
    exp_word(RD, 8'h0C, 32'hC000_1100);
    wait_done(40, "t3");
    checks++;
    if (cap_q.size() != 4) begin
      errors++;
      $display("FAIL t3_words got %0d want 4", cap_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t3_word%0d got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wqeCount !== 16'd3) begin
      errors++;
      $display("FAIL t3_count got %0d want 3", wqeCount);
    end
  endtask

  task automatic test_reject();
    int pops0;
    int errs0;
    cap_q.delete();
    pops0 = pop_cnt;
    errs0 = err_cnt;
    push_wqe(mk_wqe(5'd0, 3'd5, 8'h01, 8'd1, 8'd1, 8'd1, 8'd1, 64'h100));
    push_wqe(mk_wqe(5'd3, 3'd1, 8'h02, 8'd1, 8'd0, 8'd0, 8'd0, 64'h200));
    push_wqe(mk_wqe(5'd1, 3'd0, 8'h03, 8'd1, 8'd0, 8'd0, 8'd0, 64'h300));
    step();
    checks++;
    if (errPulse !== 1'b1 || dcsWrite !== 1'b0) begin
      errors++;
      $display("FAIL t4_first_err got err=%0b write=%0b want 1 0", errPulse, dcsWrite);
    end
    wait_done(30, "t4");
    checks++;
    if (pop_cnt - pops0 != 3) begin
      errors++;
      $display("FAIL t4_pops got %0d want 3", pop_cnt - pops0);
    end
    checks++;
    if (err_cnt - errs0 != 3) begin
      errors++;
      $display("FAIL t4_err_cycles got %0d want 3", err_cnt - errs0);
    end
    checks++;
    if (cap_q.size() != 0) begin
      errors++;
      $display("FAIL t4_words got %0d want 0", cap_q.size());
    end
    checks++;
    if (wqeCount !== 16'd3) begin
      errors++;
      $display("FAIL t4_count got %0d want 3", wqeCount);
    end
  endtask

  task automatic test_wrap();
    cap_q.delete();
    exp_q.delete();
    push_wqe(mk_wqe(5'd0, 3'd2, 8'h77, 8'd4, 8'd4, 8'd0, 8'd0, 64'hFFFF_FFFF_FFFF_FFF0));
    exp_word(RD, 8'h00, 32'hFFFF_FFF0);
    exp_word(RD, 8'h04, 32'hFFFF_FFFF);
    exp_word(RD, 8'h08, 32'h0000_0010);
    exp_word(RD, 8'h0C, 32'h8000_7700);
    exp_word(RD, 8'h00, 32'h0000_0000);
    exp_word(RD, 8'h04, 32'h0000_0000);
    exp_word(RD, 8'h08, 32'h0000_0010);
    exp_word(RD, 8'h0C, 32'hC000_7701);
    wait_done(40, "t5");
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t5_words got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t5_word%0d got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wqeCount !== 16'd4) begin
      errors++;
      $display("FAIL t5_count got %0d want 4", wqeCount);
    end
  endtask

  task automatic test_back_to_back();
    cap_q.delete();
    exp_q.delete();
    pop_cyc_q.delete();
    last_w3_cyc_q.delete();
    push_wqe(mk_wqe(5'd1, 3'd4, 8'h44, 8'd1, 8'd2, 8'd3, 8'd4, 64'h0));
    push_wqe(mk_wqe(5'd0, 3'd1, 8'h45, 8'd0, 8'd0, 8'd0, 8'd0, 64'h8));
    exp_word(WR, 8'h00, 32'h0000_0000);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_0004);
    exp_word(WR, 8'h0C, 32'h8000_4400);
    exp_word(WR, 8'h00, 32'h0000_0004);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_0008);
    exp_word(WR, 8'h0C, 32'h8000_4401);
    exp_word(WR, 8'h00, 32'h0000_000C);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_000C);
    exp_word(WR, 8'h0C, 32'h8000_4402);
    exp_word(WR, 8'h00, 32'h0000_0018);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_0010);
    exp_word(WR, 8'h0C, 32'hC000_4403);
    exp_word(RD, 8'h00, 32'h0000_0008);
    exp_word(RD, 8'h04, 32'h0000_0000);
    exp_word(RD, 8'h08, 32'h0000_0000);
    exp_word(RD, 8'h0C, 32'hC000_4500);
    wait_done(80, "b2b");
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_words got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word%0d got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pop_cyc_q.size() != 2 || last_w3_cyc_q.size() < 1) begin
      errors++;
      $display("FAIL b2b_pop_seen got pops=%0d lastw3=%0d want 2 >=1", pop_cyc_q.size(), last_w3_cyc_q.size());
    end else if (pop_cyc_q[1] < last_w3_cyc_q[0] + 1) begin
      errors++;
      $display("FAIL b2b_pop_gap got pop cycle %0d want >= %0d", pop_cyc_q[1], last_w3_cyc_q[0] + 1);
    end
    checks++;
    if (wqeCount !== 16'd6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", wqeCount);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    cap_q.delete();
    exp_q.delete();
    push_wqe(mk_wqe(5'd0, 3'd1, 8'h01, 8'd2, 8'd0, 8'd0, 8'd0, 64'h100));
    push_wqe(mk_wqe(5'd1, 3'd1, 8'h02, 8'd3, 8'd0, 8'd0, 8'd0, 64'h200));
    n = 0;
    while (!(dcsWrite === 1'b1 && dcsAddress === 8'h08) && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL t6_reach_w2 got write=%0b addr=%h want 1 08", dcsWrite, dcsAddress);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({wqePop, dcsRdSelect, dcsWrSelect, dcsWrite, busy, errPulse} !== 6'd0 ||
        dcsAddress !== 8'd0 || dcsWriteData !== 32'd0 || dcsByteEnable !== 4'd0 || wqeCount !== 16'd0) begin
      errors++;
      $display("FAIL t6_reset_outputs got pop=%0b wr=%0b busy=%0b a=%h d=%h be=%h cnt=%0d want all 0",
               wqePop, dcsWrite, busy, dcsAddress, dcsWriteData, dcsByteEnable, wqeCount);
    end
    step();
    step();
    checks++;
    if (wqePop !== 1'b0 || wqeEmpty !== 1'b0) begin
      errors++;
      $display("FAIL t6_no_pop_in_reset got pop=%0b empty=%0b want 0 0", wqePop, wqeEmpty);
    end
    cap_q.delete();
    reset = 1'b1;
    exp_word(WR, 8'h00, 32'h0000_0200);
    exp_word(WR, 8'h04, 32'h0000_0000);
    exp_word(WR, 8'h08, 32'h0000_000C);
    exp_word(WR, 8'h0C, 32'hC000_0200);
    wait_done(40, "t6");
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL t6_words got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL t6_word%0d got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wqeCount !== 16'd1) begin
      errors++;
      $display("FAIL t6_count got %0d want 1", wqeCount);
    end
  endtask

  task automatic test_protocol_totals();
    checks++;
    if (be_bad != 0) begin
      errors++;
      $display("FAIL byteenable_while_write got %0d bad cycles want 0", be_bad);
    end
    checks++;
    if (pop_bad != 0) begin
      errors++;
      $display("FAIL pop_when_empty_or_busy got %0d want 0", pop_bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) fifo_mem[i] = '0;
    test_reset();
    test_single();
    test_multi_seg();
    test_backpressure();
    test_reject();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_protocol_totals();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish by 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
